// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped line cache.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // A single-line cache has no index bits, but signals still need width 1.
    function automatic int idx_sel_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int lines);
        return addr_w - off_w(line_bytes) - idx_w(lines);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Byte storage for all cache lines: one synchronous write port, asynchronous read.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINE_BYTES = 32,
    parameter int LINES      = 4
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [idx_sel_w(LINES)-1:0]    idx_i,
    input  logic [off_w(LINE_BYTES)-1:0]   off_i,
    input  logic [7:0]                     wdata_i,
    output logic [7:0]                     rdata_o
);

    logic [7:0] bytes_q [LINES][LINE_BYTES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            bytes_q[idx_i][off_i] <= wdata_i;
        end
    end

    assign rdata_o = bytes_q[idx_i][off_i];

endmodule

// File: rtl/line_cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache. Read misses stall
// the CPU while the whole line is refilled over a req/ack memory handshake.
module line_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int LINE_BYTES = 32,
    parameter int LINES      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    input  logic              flush,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(LINES);
    localparam int IDX_WS = idx_sel_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, LINES);

    state_e               state_q;
    logic [OFF_W-1:0]     cnt_q;
    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q [LINES];

    logic [OFF_W-1:0]     off;
    logic [IDX_WS-1:0]    idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic                 fill_done;
    logic                 arr_we;
    logic [OFF_W-1:0]     arr_off;
    logic [7:0]           arr_wdata;
    logic [7:0]           arr_rdata;

    assign off = cpu_addr[OFF_W-1:0];
    assign tag = cpu_addr[ADDR_W-1 -: TAG_W];

    if (IDX_W > 0) begin : g_idx
        assign idx = cpu_addr[OFF_W +: IDX_WS];
    end else begin : g_noidx
        assign idx = '0;
    end

    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign fill_done = (state_q == FILL) && mem_ack && (&cnt_q);

    // Fill beats always land; a write only touches the array when it hits.
    assign arr_we    = mem_ack && ((state_q == FILL) || ((state_q == WRITE) && hit));
    assign arr_off   = (state_q == FILL) ? cnt_q : off;
    assign arr_wdata = (state_q == FILL) ? mem_rdata : cpu_wdata;

    cache_line_array #(
        .LINE_BYTES (LINE_BYTES),
        .LINES      (LINES)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (idx),
        .off_i   (arr_off),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (cpu_wr) begin
                        state_q <= WRITE;
                    end else if (cpu_rd && !hit) begin
                        cnt_q   <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (&cnt_q) begin
                            // Overrides a coincident flush: this line is fresh from memory.
                            valid_q[idx] <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx] <= tag;
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    cpu_ready = !cpu_wr && (!cpu_rd || hit);
                    if (!cpu_wr && cpu_rd && hit) begin
                        cpu_rdata = arr_rdata;
                    end
                end
                FILL: begin
                    mem_rd   = 1'b1;
                    mem_addr = {cpu_addr[ADDR_W-1:OFF_W], cnt_q};
                end
                WRITE: begin
                    mem_wr    = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    cpu_ready = mem_ack;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_cache.sv
// Scoreboard bench for line_cache: drivers queue expected memory and CPU
// responses, a negedge monitor pops and compares them as the DUT produces them.
module tb_line_cache;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_addr;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       flush;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } mexp_t;

    // mode 0: ready in the issue cycle; 1: one cycle after last ack; 2: on the ack cycle
    typedef struct {
        bit         is_rd;
        logic [7:0] data;
        int         mode;
    } cexp_t;

    mexp_t mq[$];
    cexp_t cq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int issue_cyc = 0;
    int last_ack  = -10;
    int lat       = 0;

    line_cache #(
        .ADDR_W     (8),
        .LINE_BYTES (32),
        .LINES      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .flush     (flush),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Memory model: data = addr ^ 0xA5, ack two cycles into each request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
                lat     = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                lat     = 0;
            end else if (mem_rd || mem_wr) begin
                lat++;
                if (lat >= 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 8'hA5;
                end
            end else begin
                lat = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        mexp_t me;
        cexp_t ce;
        int    want_cyc;
        if (mem_rd && mem_wr) chk("mem_rd_wr_exclusive", 1, 0);
        if (mem_ack && (mem_rd || mem_wr)) begin
            last_ack = cyc;
            if (mq.size() == 0) begin
                chk("mem_unexpected_addr", {23'd0, mem_wr, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                me = mq.pop_front();
                chk("mem_kind", {31'd0, mem_wr}, {31'd0, me.wr});
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, me.addr});
                if (me.wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, me.data});
            end
        end
        if (cpu_ready && (cpu_rd || cpu_wr)) begin
            if (cq.size() == 0) begin
                chk("cpu_unexpected_ready", 1, 0);
            end else begin
                ce = cq.pop_front();
                if (ce.is_rd) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, ce.data});
                case (ce.mode)
                    0:       want_cyc = issue_cyc;
                    1:       want_cyc = last_ack + 1;
                    default: want_cyc = last_ack;
                endcase
                chk("cpu_ready_cycle", cyc, want_cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) break;
            n++;
            if (n > 400) begin
                chk("cpu_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #2;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d, input bit miss);
        logic [7:0] base;
        base = a & 8'hE0;
        if (miss) begin
            for (int i = 0; i < 32; i++) mq.push_back('{1'b0, base | 8'(i), 8'h00});
        end
        cq.push_back('{1'b1, d, miss ? 1 : 0});
        @(posedge clk);
        #2;
        cpu_addr  = a;
        cpu_rd    = 1'b1;
        issue_cyc = cyc;
        wait_ready();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        mq.push_back('{1'b1, a, d});
        cq.push_back('{1'b0, 8'h00, 2});
        @(posedge clk);
        #2;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        issue_cyc = cyc;
        wait_ready();
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        cpu_addr  = 8'h00;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = 8'h00;
        flush     = 1'b0;
        #3;
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("idle_ready_no_req", {31'd0, cpu_ready}, 1);

        do_read(8'h05, 8'hA0, 1'b1);
        do_read(8'h1F, 8'hBA, 1'b0);
        do_write(8'h10, 8'h3C);
        do_read(8'h10, 8'h3C, 1'b0);
        do_read(8'h85, 8'h20, 1'b1);
        do_read(8'h05, 8'hA0, 1'b1);
        do_write(8'h40, 8'h77);
        do_read(8'h40, 8'hE5, 1'b1);
        do_read(8'h5F, 8'hFA, 1'b0);

        // Flush forces a resident line to miss again.
        do_read(8'h85, 8'h20, 1'b1);
        do_read(8'h85, 8'h20, 1'b0);
        pulse_flush();
        do_read(8'h85, 8'h20, 1'b1);

        // Reset in the middle of a refill abandons it.
        pulse_flush();
        for (int i = 0; i < 10; i++) mq.push_back('{1'b0, 8'h80 | 8'(i), 8'h00});
        @(posedge clk);
        #2;
        cpu_addr = 8'h85;
        cpu_rd   = 1'b1;
        n = 0;
        for (int t = 0; t < 400 && n < 10; t++) begin
            @(negedge clk);
            if (mem_ack && mem_rd) n++;
        end
        chk("acks_before_reset", n, 10);
        @(posedge clk);
        #2;
        chk("fill_active_before_reset", {31'd0, mem_rd}, 1);
        reset  = 1'b1;
        cpu_rd = 1'b0;
        #1;
        chk("midfill_rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("midfill_rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("midfill_rst_cpu_ready", {31'd0, cpu_ready}, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        do_read(8'h85, 8'h20, 1'b1);
        do_read(8'h9F, 8'h3A, 1'b0);

        repeat (8) @(posedge clk);
        chk("mem_queue_drained", mq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_cache.md
# line_cache

Parametrised direct-mapped, write-through, no-write-allocate byte cache between the CPU data port and backing memory. Holds LINES lines of LINE_BYTES bytes, each with a tag and a valid bit. Read hits complete in the request cycle. Misses stall the CPU while an FSM refills the whole line over a req/ack memory handshake. Supersedes the single-line, tagless offset cache.

## Interface
- ADDR_W, default 8: byte address width; must be > log2(LINES)+log2(LINE_BYTES)
- LINE_BYTES, default 32: bytes per line; power of two, ≥2
- LINES, default 4: number of lines; power of two, ≥1
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- cpu_addr  in  ADDR_W  byte address, held stable until accepted
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request; has priority over cpu_rd if both are high
- cpu_wdata  in  8  write byte
- flush  in  1  one-cycle pulse; invalidates all lines
- cpu_rdata  out  8  read byte; valid when cpu_ready & cpu_rd
- cpu_ready  out  1  request accepted/completed this cycle
- mem_addr  out  ADDR_W  memory byte address
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte; sampled on mem_ack
- mem_ack  in  1  one-cycle transfer acknowledge

## Operation
- Address split: offset = low OFF_W = log2(LINE_BYTES) bits; index = next IDX_W = log2(LINES) bits; tag = remaining bits.
- Hit: valid[index] & tag_array[index] == tag.
- FSM states:
  - IDLE. With no request: cpu_ready=1. Read hit: cpu_ready=1 and cpu_rdata = array byte, combinational, same cycle. Read miss: cpu_ready=0, counter cleared, next state FILL. Write (hit or miss): cpu_ready=0, next state WRITE.
  - FILL. mem_rd=1, mem_addr = {tag, index, cnt}. On each mem_ack: store mem_rdata at byte cnt of the line, then cnt++. On the ack with cnt == LINE_BYTES-1: set tag_array[index] and valid[index], next state IDLE, where the held read now hits.
  - WRITE. mem_wr=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata. On mem_ack: cpu_ready=1 in the same cycle, next state IDLE. If the access was a hit, the byte is updated in the array on the ack edge. A miss allocates nothing.
- Memory handshake:
  - mem_rd/mem_wr, mem_addr and mem_wdata are held stable until mem_ack.
  - Consecutive fill beats are issued back-to-back; the address increments on the cycle after each ack.
- Flush: clears all valid bits on the next edge, in any state. A fill in progress still completes and sets its valid bit, because that data is fresh from memory.
- Only one of mem_rd/mem_wr is ever high.

## Timing
- Read hit: 0-cycle latency; cpu_ready is high in the request cycle.
- Read miss: cpu_ready goes high 1 cycle after the final fill ack, i.e. LINE_BYTES acks + 1 cycle.
- Write: cpu_ready is high in the mem_ack cycle.
- A request is consumed on the cycle with cpu_ready=1. The CPU must deassert or change the request on the following cycle.
- Reset, immediate and asynchronous:
  - State → IDLE, cnt=0, all valid bits cleared.
  - cpu_ready=0, cpu_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0 while reset is high.
  - Data and tag arrays are not reset.
- Reset mid-FILL or mid-WRITE abandons the memory transaction. Memory must tolerate a request dropped without ack.
- A mem_ack received outside FILL/WRITE is ignored.

## Structure
- Shared package cache_pkg:
  - state enum {IDLE, FILL, WRITE}
  - functions/localparams for OFF_W, IDX_W, TAG_W derived from the parameters
- Sub-module cache_line_array:
  - LINES×LINE_BYTES byte storage
  - one synchronous byte-write port (index, offset, data, we)
  - asynchronous byte read (index, offset)
- Tags, valid bits, FSM and counter live in line_cache.

## Test plan
Defaults (ADDR_W=8, 32-byte lines, 4 lines). Memory model returns addr^0xA5 with ack latency 2.
- Reset, then read 0x05 → 32 mem_rd beats at addresses 0x00..0x1F; cpu_ready high 1 cycle after the last ack with cpu_rdata=0xA0.
- Read 0x1F straight after → cpu_ready in the same cycle, cpu_rdata=0xBA, no mem_rd.
- Write 0x10 with data 0x3C (hit) → mem_wr at 0x10 with data 0x3C; cpu_ready on the ack cycle; then read 0x10 hits with 0x3C.
- Read 0x85 (index 0, tag 1) → refill 0x80..0x9F, cpu_rdata=0x20; read 0x05 then misses again.
- Write 0x40 (miss) → single mem_wr, no fill; a following read of 0x40 misses and refills 0x40..0x5F.
- Two separate checks:
  - Pulse flush, then read 0x85 → miss.
  - Assert reset after the 10th ack of a fill → mem_rd low immediately; after release, read 0x85 refills starting at 0x80.
